// File: rtl/sound_glu.sv
`timescale 1ns/1ps
// sound_glu -- CPU-side responder for the Apple IIgs Sound GLU soft switches
// $C03C..$C03F (SOUNDCTL, SOUNDDATA, SOUNDADRL, SOUNDADRH).
//
// Holds the GLU control/address/data latches and the 256-byte DOC register
// file, and reaches the 64 KB sound RAM through a req/ack memory port.
//
// Ports:
//   clk_sys, reset       system clock, asynchronous active-high reset
//   cen                  clock enable, only advances the ack timeout counter
//   addr, rw, din, dout  I/O bus (addr low byte, 1 = read), registered dout
//   strobe               one-clk_sys access pulse
//   ram_req/we/addr/wdata, ram_rdata, ram_ack   sound RAM request port
//   doc_raddr, doc_rdata DOC register read port (1-clk latency)
//   volume               SOUNDCTL[3:0]
module sound_glu #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cen,
  input  logic [7:0]  addr,
  input  logic        rw,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        strobe,
  output logic        ram_req,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  input  logic        ram_ack,
  input  logic [7:0]  doc_raddr,
  output logic [7:0]  doc_rdata,
  output logic [3:0]  volume
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        ctl_ram_reg;       // 1 = SOUNDDATA targets sound RAM
  logic        ctl_inc_reg;       // auto-increment enable
  logic [3:0]  ctl_vol_reg;
  logic [15:0] adr_reg;
  logic [7:0]  latch_reg;
  logic [7:0]  tmo_cnt_reg;
  logic [7:0]  regfile [0:255];

  logic busy, hit, data_ok, ram_start, doc_wr, ack_done, tmo_done;
  logic unused_din;

  assign unused_din = &{1'b0, din[7], din[4]};

  assign busy      = (state_reg == WAIT);
  assign hit       = strobe && (addr[7:2] == 6'b001111);
  // An accepted SOUNDDATA access; a busy GLU (including the ack edge) refuses it.
  assign data_ok   = hit && (addr[1:0] == 2'd1) && !busy;
  assign ram_start = data_ok && ctl_ram_reg;
  assign doc_wr    = data_ok && !ctl_ram_reg && !rw;
  assign ack_done  = busy && ram_ack;
  assign tmo_done  = busy && !ram_ack && cen && (tmo_cnt_reg == TMO_LAST);
  assign volume    = ctl_vol_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (ram_start) state_next = WAIT;
      WAIT: if (ack_done || tmo_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // DOC register file: not reset, written by CPU SOUNDDATA writes in DOC mode.
  always_ff @(posedge clk_sys) begin
    if (doc_wr) regfile[adr_reg[7:0]] <= din;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dout        <= 8'h00;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= 16'h0000;
      ram_wdata   <= 8'h00;
      doc_rdata   <= 8'h00;
      ctl_ram_reg <= 1'b0;
      ctl_inc_reg <= 1'b0;
      ctl_vol_reg <= 4'h0;
      adr_reg     <= 16'h0000;
      latch_reg   <= 8'h00;
      tmo_cnt_reg <= 8'h00;
    end else begin
      // Non-blocking read: a same-edge CPU write shows up one clock later.
      doc_rdata <= regfile[doc_raddr];

      // Completion of an outstanding RAM access (ack wins over timeout).
      if (busy) begin
        if (ack_done) begin
          ram_req <= 1'b0;
          if (!ram_we) latch_reg <= ram_rdata;
        end else if (tmo_done) begin
          ram_req <= 1'b0;
          if (!ram_we) latch_reg <= 8'hFF;
        end else if (cen) begin
          tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
        end
      end

      if (hit) begin
        case (addr[1:0])
          2'd0: begin
            if (rw) begin
              dout <= {busy, ctl_ram_reg, ctl_inc_reg, 1'b0, ctl_vol_reg};
            end else begin
              ctl_vol_reg <= din[3:0];
              if (!busy) begin
                ctl_ram_reg <= din[6];
                ctl_inc_reg <= din[5];
              end
            end
          end
          2'd1: begin
            // Double-read semantics: the CPU sees the previous fetch.
            if (rw) dout <= latch_reg;
            if (!busy) begin
              if (ctl_ram_reg) begin
                ram_req     <= 1'b1;
                ram_we      <= !rw;
                ram_addr    <= adr_reg;
                tmo_cnt_reg <= 8'h00;
                if (!rw) ram_wdata <= din;
              end else if (rw) begin
                latch_reg <= regfile[adr_reg[7:0]];
              end
              if (ctl_inc_reg) begin
                if (ctl_ram_reg) adr_reg <= adr_reg + 16'd1;
                else             adr_reg[7:0] <= adr_reg[7:0] + 8'd1;
              end
            end
          end
          2'd2: begin
            if (rw)         dout <= adr_reg[7:0];
            else if (!busy) adr_reg[7:0] <= din;
          end
          default: begin
            if (rw)         dout <= adr_reg[15:8];
            else if (!busy) adr_reg[15:8] <= din;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_glu.sv
`timescale 1ns/1ps
// tb_sound_glu -- directed plus randomized bench for sound_glu with a
// transaction-level reference model of the GLU latches, DOC file and RAM.
module tb_sound_glu;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        cen     = 1'b0;
  logic [7:0]  addr    = 8'h00;
  logic        rw      = 1'b1;
  logic [7:0]  din     = 8'h00;
  logic        strobe  = 1'b0;
  logic [7:0]  ram_rdata = 8'h00;
  logic        ram_ack = 1'b0;
  logic [7:0]  doc_raddr = 8'h00;
  logic [7:0]  dout, doc_rdata, ram_wdata;
  logic        ram_req, ram_we;
  logic [15:0] ram_addr;
  logic [3:0]  volume;

  int errors = 0;
  int checks = 0;

  sound_glu #(.ACK_TIMEOUT(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .cen(cen), .addr(addr), .rw(rw),
    .din(din), .dout(dout), .strobe(strobe), .ram_req(ram_req),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .doc_raddr(doc_raddr),
    .doc_rdata(doc_rdata), .volume(volume)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic        m_ram, m_inc, m_pend, m_pend_rd;
  logic [3:0]  m_vol;
  logic [15:0] m_adr, m_pend_addr;
  logic [7:0]  m_latch, m_dout, m_pend_wdata;
  logic [7:0]  m_doc [256];
  logic [7:0]  mem [int];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ram = 0; m_inc = 0; m_vol = 0; m_adr = 0; m_latch = 0; m_dout = 0;
    m_pend = 0; m_pend_rd = 0; m_pend_addr = 0; m_pend_wdata = 0;
  endtask

  // Effect of one CPU access on the model; m_pend stands for "GLU busy".
  task automatic m_strobe(input logic [7:0] a, input logic r, input logic [7:0] d);
    if (a == 8'h3C) begin
      if (r) m_dout = {m_pend, m_ram, m_inc, 1'b0, m_vol};
      else begin
        m_vol = d[3:0];
        if (!m_pend) begin m_ram = d[6]; m_inc = d[5]; end
      end
    end else if (a == 8'h3D) begin
      if (r) m_dout = m_latch;
      if (!m_pend) begin
        if (m_ram) begin
          m_pend = 1; m_pend_rd = r; m_pend_addr = m_adr; m_pend_wdata = d;
        end else if (r) m_latch = m_doc[m_adr[7:0]];
        else m_doc[m_adr[7:0]] = d;
        if (m_inc) begin
          if (m_ram) m_adr = m_adr + 16'd1;
          else m_adr[7:0] = m_adr[7:0] + 8'd1;
        end
      end
    end else if (a == 8'h3E) begin
      if (r) m_dout = m_adr[7:0];
      else if (!m_pend) m_adr[7:0] = d;
    end else if (a == 8'h3F) begin
      if (r) m_dout = m_adr[15:8];
      else if (!m_pend) m_adr[15:8] = d;
    end
  endtask

  task automatic m_finish(input logic [7:0] v);
    if (m_pend_rd) m_latch = v;
    m_pend = 0;
  endtask

  task automatic cpu(input logic [7:0] a, input logic r, input logic [7:0] d);
    @(negedge clk_sys);
    addr = a; rw = r; din = d; strobe = 1'b1;
    @(negedge clk_sys);
    strobe = 1'b0; rw = 1'b1; addr = 8'h00;
    m_strobe(a, r, d);
    $display("txn addr=%h rw=%b din=%h dout=%h vol=%h req=%b", a, r, d, dout, volume, ram_req);
    chk($sformatf("dout@%h rw=%b", a, r), {8'h00, dout}, {8'h00, m_dout});
    chk("volume", {12'h000, volume}, {12'h000, m_vol});
  endtask

  task automatic start_chk();
    chk("ram_req_start", {15'h0, ram_req}, 16'h0001);
    chk("ram_addr", ram_addr, m_pend_addr);
    chk("ram_we", {15'h0, ram_we}, {15'h0, !m_pend_rd});
    if (!m_pend_rd) chk("ram_wdata", {8'h00, ram_wdata}, {8'h00, m_pend_wdata});
  endtask

  // Memory responder: ack arrives dly clocks after the request edge.
  task automatic serve(input int dly);
    logic [7:0] v;
    int ia;
    ia = int'(m_pend_addr);
    repeat (dly - 1) @(negedge clk_sys);
    chk("ram_req_hold", {15'h0, ram_req}, 16'h0001);
    if (m_pend_rd) begin
      if (mem.exists(ia)) v = mem[ia];
      else begin v = 8'($urandom); mem[ia] = v; end
    end else begin
      v = 8'($urandom);
      mem[ia] = m_pend_wdata;
    end
    ram_rdata = v; ram_ack = 1'b1;
    @(negedge clk_sys);
    ram_ack = 1'b0;
    m_finish(v);
    chk("ram_req_drop", {15'h0, ram_req}, 16'h0000);
  endtask

  initial begin
    int ticks;
    logic [7:0] a, d, old;
    logic r;
    int sel;

    m_reset();
    repeat (3) @(negedge clk_sys);
    chk("rst_dout", {8'h00, dout}, 16'h0000);
    chk("rst_ram_req", {15'h0, ram_req}, 16'h0000);
    chk("rst_ram_we", {15'h0, ram_we}, 16'h0000);
    chk("rst_ram_addr", ram_addr, 16'h0000);
    chk("rst_ram_wdata", {8'h00, ram_wdata}, 16'h0000);
    chk("rst_doc_rdata", {8'h00, doc_rdata}, 16'h0000);
    chk("rst_volume", {12'h000, volume}, 16'h0000);
    reset = 1'b0;

    // Fill the DOC file so later reads are defined.
    cpu(8'h3C, 0, 8'h20); cpu(8'h3E, 0, 8'h00); cpu(8'h3F, 0, 8'h00);
    for (int i = 0; i < 256; i++) cpu(8'h3D, 0, 8'($urandom));

    // RAM write with auto-increment, status read while waiting.
    cpu(8'h3C, 0, 8'h60); cpu(8'h3E, 0, 8'hFE); cpu(8'h3F, 0, 8'h12);
    cpu(8'h3D, 0, 8'hAA);
    start_chk();
    chk("t1_ram_addr", ram_addr, 16'h12FE);
    chk("t1_ram_wdata", {8'h00, ram_wdata}, 16'h00AA);
    cpu(8'h3C, 1, 8'h00);
    chk("t1_ctl_busy", {8'h00, dout}, 16'h00E0);
    serve(2);
    cpu(8'h3E, 1, 8'h00);
    cpu(8'h3F, 1, 8'h00);
    chk("t1_adrh", {8'h00, dout}, 16'h0012);

    // RAM reads wrapping FFFF -> 0000.
    mem[32'hFFFF] = 8'h11; mem[0] = 8'h22;
    cpu(8'h3E, 0, 8'hFF); cpu(8'h3F, 0, 8'hFF);
    cpu(8'h3D, 1, 8'h00); start_chk(); serve(1);
    cpu(8'h3D, 1, 8'h00);
    chk("t2_second_read", {8'h00, dout}, 16'h0011);
    start_chk();
    chk("t2_wrap_addr", ram_addr, 16'h0000);
    serve(3);
    cpu(8'h3E, 1, 8'h00);
    chk("t2_adrl", {8'h00, dout}, 16'h0001);
    cpu(8'h3F, 1, 8'h00);

    // DOC write with 8-bit wrap, read port latency and same-edge old value.
    cpu(8'h3C, 0, 8'h20); cpu(8'h3E, 0, 8'hFF); cpu(8'h3F, 0, 8'h34);
    cpu(8'h3D, 0, 8'h5A);
    cpu(8'h3E, 1, 8'h00);
    chk("t3_adrl", {8'h00, dout}, 16'h0000);
    cpu(8'h3F, 1, 8'h00);
    chk("t3_adrh", {8'h00, dout}, 16'h0034);
    doc_raddr = 8'hFF;
    @(negedge clk_sys);
    chk("t3_doc_rdata", {8'h00, doc_rdata}, 16'h005A);
    cpu(8'h3E, 0, 8'h10);
    doc_raddr = 8'h10;
    old = m_doc[8'h10];
    cpu(8'h3D, 0, ~old);
    chk("t3_doc_old", {8'h00, doc_rdata}, {8'h00, old});
    @(negedge clk_sys);
    chk("t3_doc_new", {8'h00, doc_rdata}, {8'h00, ~old});

    // Timeout: no ack, cen every other clock.
    cpu(8'h3C, 0, 8'h40);
    cpu(8'h3D, 1, 8'h00);
    start_chk();
    ticks = 0;
    for (int i = 0; i < 40 && ram_req; i++) begin
      cen = (i % 2 == 1);
      @(negedge clk_sys);
      if (cen) ticks++;
    end
    cen = 1'b0;
    chk("t4_ticks", 16'(ticks), 16'd4);
    chk("t4_req_dropped", {15'h0, ram_req}, 16'h0000);
    m_finish(8'hFF);
    cpu(8'h3C, 1, 8'h00);
    cpu(8'h3D, 1, 8'h00);
    chk("t4_timeout_data", {8'h00, dout}, 16'h00FF);
    start_chk(); serve(2);

    // Accesses while busy.
    cpu(8'h3C, 0, 8'h60); cpu(8'h3E, 0, 8'h20); cpu(8'h3F, 0, 8'h00);
    cpu(8'h3D, 0, 8'h44); start_chk();
    cpu(8'h3D, 0, 8'h99);
    chk("t5_busy_addr", ram_addr, 16'h0020);
    chk("t5_busy_wdata", {8'h00, ram_wdata}, 16'h0044);
    cpu(8'h3E, 0, 8'h55);
    cpu(8'h3C, 0, 8'h0F);
    chk("t5_volume", {12'h000, volume}, 16'h000F);
    cpu(8'h3C, 1, 8'h00);
    chk("t5_ctl", {8'h00, dout}, 16'h00EF);
    serve(1);
    cpu(8'h3E, 1, 8'h00);
    chk("t5_adrl", {8'h00, dout}, 16'h0021);

    // Reset in the middle of a RAM read; a late ack must be ignored.
    cpu(8'h3D, 1, 8'h00); start_chk();
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    chk("t6_req_async", {15'h0, ram_req}, 16'h0000);
    chk("t6_dout", {8'h00, dout}, 16'h0000);
    chk("t6_ram_addr", ram_addr, 16'h0000);
    m_reset();
    @(negedge clk_sys);
    reset = 1'b0;
    ram_rdata = 8'hC3; ram_ack = 1'b1;
    @(negedge clk_sys);
    ram_ack = 1'b0;
    chk("t6_no_req", {15'h0, ram_req}, 16'h0000);
    cpu(8'h3E, 1, 8'h00); cpu(8'h3F, 1, 8'h00); cpu(8'h3C, 1, 8'h00);
    cpu(8'h3D, 1, 8'h00);
    chk("t6_latch", {8'h00, dout}, 16'h0000);

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) a = 8'h3C + 8'(sel % 4);
      else a = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      doc_raddr = 8'($urandom);
      cpu(a, r, d);
      if (m_pend) begin
        start_chk();
        serve($urandom_range(1, 3));
      end
      @(negedge clk_sys);
      chk("rnd_doc_rdata", {8'h00, doc_rdata}, {8'h00, m_doc[doc_raddr]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_glu.md
Name: sound_glu

Overview:
- Peripheral-side responder for the Apple IIgs Sound GLU soft switches $C03C–$C03F (SOUNDCTL, SOUNDDATA, SOUNDADRL, SOUNDADRH).
- Sits behind the CPU I/O decoder on the same strobe/rw/addr/din/dout interface used by the ADB, RTC and IWM responders.
- Holds the GLU control, address and data latches, and a 256-byte DOC register file.
- Accesses the 64 KB sound RAM through an external req/ack memory port.

Parameters:
- ACK_TIMEOUT, 255: cen ticks to wait for ram_ack before aborting a RAM access (1..255).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cen  in  1  clock enable (fast_clk); used only for the timeout counter
- addr  in  8  I/O address low byte; 8'h3C..8'h3F decoded, others ignored
- rw  in  1  1 = read, 0 = write
- din  in  8  CPU write data
- dout  out  8  read data to the I/O mux
- strobe  in  1  one-clk_sys access pulse
- ram_req  out  1  sound RAM request
- ram_we  out  1  1 = write
- ram_addr  out  16  sound RAM address
- ram_wdata  out  8  sound RAM write data
- ram_rdata  in  8  sound RAM read data, valid with ram_ack
- ram_ack  in  1  one-clk pulse completing a request
- doc_raddr  in  8  DOC register read address, for the future DOC engine
- doc_rdata  out  8  DOC register read data, registered with 1-clk latency
- volume  out  4  SOUNDCTL[3:0]

Behaviour:
Reset values:
- dout = 0, ram_req = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, doc_rdata = 0, volume = 0.
- ctl = 0, adr = 16'h0000, data latch = 0, state = IDLE.
- The DOC register file is not reset.

Strobe handling:
- Strobe is sampled on the clk_sys edge.
- dout is registered: it is updated on the edge where strobe = 1 and rw = 1, and holds until the next read strobe.
- A strobe with addr outside 3C..3F: no state change, dout unchanged.

SOUNDCTL ($C03C):
- Read returns {busy, ctl[6:5], 1'b0, ctl[3:0]}.
- Write latches din[6:5] and din[3:0]; bits 7 and 4 are ignored.
- ctl[6] = 1 selects RAM; 0 selects the DOC register file.
- ctl[5] = 1 enables auto-increment.
- A write while busy updates only bits [3:0].

SOUNDADRL / SOUNDADRH ($C03E / $C03F):
- Read returns adr[7:0] / adr[15:8].
- A write while busy is ignored.

SOUNDDATA ($C03D) write:
- Write while busy: ignored entirely, no address increment.
- DOC mode: regfile[adr[7:0]] <= din on the same edge.
- RAM mode:
  - Next edge: ram_addr = adr, ram_wdata = din, ram_we = 1, ram_req = 1; state -> WAIT.

SOUNDDATA ($C03D) read:
- dout = the data latch as it was before the strobe (IIgs double-read semantics).
- Then a read access starts at adr. Read while busy: dout = latch, and no access starts.
- DOC mode: latch <= regfile[adr[7:0]] on the same edge.
- RAM mode: ram_we = 0, ram_req = 1; state -> WAIT.
  - On ram_ack, latch <= ram_rdata.

Auto-increment:
- Applied on the strobe edge of any accepted SOUNDDATA access when ctl[5] = 1.
- RAM mode: 16-bit increment, FFFF -> 0000.
- DOC mode: adr[7:0] only, FF -> 00; adr[15:8] unchanged.
- The in-flight RAM access uses the pre-increment address.

State machine IDLE / WAIT:
- busy = (state == WAIT). ram_req stays high through WAIT.
- On ram_ack in WAIT: ram_req = 0 and state -> IDLE on that edge.
  - Read accesses latch ram_rdata on that edge.
- Timeout counter:
  - Cleared on entry to WAIT; increments on cen while in WAIT.
  - On reaching ACK_TIMEOUT without an ack: ram_req = 0, state -> IDLE, and a read access loads latch = 8'hFF.
- ram_ack while IDLE is ignored.
- ram_ack and a new strobe on the same edge: the ack completes first, but the strobe is still treated as busy.

DOC read port:
- doc_rdata <= regfile[doc_raddr] every clk_sys edge.
- If a CPU write to the same address happens on the same edge, the old value is returned.

Reset mid-transaction:
- Everything returns to reset values immediately; ram_req drops asynchronously.
- A pending ack is dropped.

Test Plan:
- Write $C03C=8'h60, $C03E=8'hFE, $C03F=8'h12; write $C03D=8'hAA, ack after 3 clk -> ram_req high 3 clk with ram_addr=16'h12FE, ram_we=1, ram_wdata=8'hAA; afterwards adr=16'h12FF; reading $C03C during the wait returns 8'hE0.
- RAM mode, auto-increment on, adr=16'hFFFF; two data reads, memory returns 8'h11 at FFFF and 8'h22 at 0000 -> dout = old latch, then 8'h11; final adr=16'h0001.
- DOC mode, $C03C=8'h20, adr=16'h34FF; write 8'h5A -> regfile[FF]=8'h5A, adr=16'h3400; doc_raddr=8'hFF gives doc_rdata=8'h5A one clk later.
- Start a RAM read and never ack, ACK_TIMEOUT=4, cen every 2 clk -> ram_req drops after 4 cen ticks, busy=0, next data read returns 8'hFF.
- While busy: write $C03D, write $C03E, write $C03C=8'h0F -> no new request, adr unchanged, volume=4'hF, ctl[6:5] unchanged.
- Assert reset during WAIT -> ram_req=0, dout=0, adr=0, state IDLE; a late ram_ack has no effect.
